// File: rtl/parking_pkg.sv
// ============================================================================
//  Module      : parking_pkg
//  Description : Shared types and default constants for the parking occupancy
//                controller: gate FSM state encoding, default parameter values
//                and the statistics counter width.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package parking_pkg;

  // Barrier gate state. The gate output is open in every state except ST_IDLE.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_OPEN     = 2'd1,
    ST_WAIT_CLR = 2'd2
  } gate_state_t;

  localparam int c_def_capacity        = 8;
  localparam int c_def_cnt_w           = 4;
  localparam int c_def_debounce_cycles = 4;
  localparam int c_def_gate_cycles     = 250;

  // Width of the optional entry/reject statistics counters.
  localparam int c_stats_w = 16;

endpackage : parking_pkg

`default_nettype wire

// File: rtl/sensor_debounce.sv
// ============================================================================
//  Module      : sensor_debounce
//  Description : Sensor front end. Two-flop synchronizer, then a debounce
//                counter that accepts a new level only after DEBOUNCE_CYCLES
//                consecutive synchronized samples of that level, then a
//                registered rising-edge detector on the debounced level.
//  Ports       : clk        - system clock
//                rst        - asynchronous active-high reset
//                sensor_raw - raw asynchronous sensor input
//                level      - debounced sensor level
//                rise_evt   - one-cycle pulse on a debounced rising edge
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sensor_debounce
  import parking_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = c_def_debounce_cycles
) (
  input  logic clk,
  input  logic rst,
  input  logic sensor_raw,
  output logic level,
  output logic rise_evt
);

  // The counter only ever has to reach DEBOUNCE_CYCLES-1.
  localparam int c_cnt_w = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);

  logic               r_sync1;
  logic               r_sync2;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_level;
  logic               r_level_d;
  logic               r_evt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_evt     <= 1'b0;
    end else begin
      r_sync1   <= sensor_raw;
      r_sync2   <= r_sync1;
      r_level_d <= r_level;
      r_evt     <= r_level & ~r_level_d;
      // Count samples that disagree with the accepted level; any agreeing
      // sample restarts the run, so short bounces never get through.
      if (r_sync2 != r_level) begin
        if (r_cnt == c_cnt_last) begin
          r_level <= r_sync2;
          r_cnt   <= '0;
        end else begin
          r_cnt   <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign level    = r_level;
  assign rise_evt = r_evt;

endmodule : sensor_debounce

`default_nettype wire

// File: rtl/parking_occupancy_ctrl.sv
// ============================================================================
//  Module      : parking_occupancy_ctrl
//  Description : Parking lot occupancy tracker and barrier gate controller.
//                Debounces the entry/exit sensors, runs one gate FSM per
//                barrier, keeps a non-wrapping occupancy count and emits
//                single-cycle full_signal / exit_err pulses.
//  Ports       : clk, rst (asynchronous, active-high)
//                entry_sensor, exit_sensor - raw car-present inputs
//                entry_gate, exit_gate     - barrier open outputs
//                occupancy                 - current car count
//                full_signal               - pulse on reaching capacity or on
//                                            a refused entry
//                exit_err                  - pulse on an exit while empty
//                total_entries, reject_count (only with PARK_STATS_EN)
//  Config      : define PARK_STATS_EN to add the saturating statistics
//                counters and their output ports.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module parking_occupancy_ctrl
  import parking_pkg::*;
#(
  parameter int CAPACITY        = c_def_capacity,
  parameter int CNT_W           = c_def_cnt_w,
  parameter int DEBOUNCE_CYCLES = c_def_debounce_cycles,
  parameter int GATE_CYCLES     = c_def_gate_cycles
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             entry_sensor,
  input  logic             exit_sensor,
  output logic             entry_gate,
  output logic             exit_gate,
  output logic [CNT_W-1:0] occupancy,
  output logic             full_signal,
  output logic             exit_err
`ifdef PARK_STATS_EN
  ,
  output logic [c_stats_w-1:0] total_entries,
  output logic [c_stats_w-1:0] reject_count
`endif
);

  localparam logic [CNT_W-1:0] c_cap = CNT_W'(CAPACITY);
  localparam int c_tmr_w = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [c_tmr_w-1:0] c_tmr_last = c_tmr_w'(GATE_CYCLES - 1);

  // Index 0 is the entry side, index 1 the exit side.
  logic [1:0] w_raw;
  logic [1:0] w_level;
  logic [1:0] w_evt;
  logic [1:0] w_idle;
  logic [1:0] w_gate;
  logic [1:0] w_accept;

  assign w_raw = {exit_sensor, entry_sensor};

  // --------------------------------------------------------------------------
  // Sensor front ends
  // --------------------------------------------------------------------------
  for (genvar g = 0; g < 2; g++) begin : g_sensor
    sensor_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_sensor_debounce (
      .clk        (clk),
      .rst        (rst),
      .sensor_raw (w_raw[g]),
      .level      (w_level[g]),
      .rise_evt   (w_evt[g])
    );
  end

  // --------------------------------------------------------------------------
  // Gate FSMs
  // --------------------------------------------------------------------------
  for (genvar g = 0; g < 2; g++) begin : g_gate
    gate_state_t        r_state;
    gate_state_t        w_state_nxt;
    logic [c_tmr_w-1:0] r_tmr;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_state <= ST_IDLE;
        r_tmr   <= '0;
      end else begin
        r_state <= w_state_nxt;
        // Timer is held at zero outside OPEN so every opening starts fresh.
        r_tmr   <= (r_state == ST_OPEN) ? r_tmr + 1'b1 : '0;
      end
    end

    always_comb begin
      w_state_nxt = r_state;
      case (r_state)
        ST_IDLE:     if (w_accept[g])        w_state_nxt = ST_OPEN;
        ST_OPEN:     if (r_tmr == c_tmr_last) w_state_nxt = ST_WAIT_CLR;
        ST_WAIT_CLR: if (!w_level[g])        w_state_nxt = ST_IDLE;
        default:                             w_state_nxt = ST_IDLE;
      endcase
    end

    assign w_idle[g] = (r_state == ST_IDLE);
    assign w_gate[g] = (r_state != ST_IDLE);
  end

  // --------------------------------------------------------------------------
  // Occupancy decision
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0] r_occ;
  logic             r_full;
  logic             r_exit_err;

  logic [1:0]       w_evt_live;
  logic             w_exit_ok;
  logic             w_exit_bad;
  logic             w_entry_ok;
  logic             w_entry_rej;
  logic [CNT_W-1:0] w_occ_after_exit;
  logic [CNT_W-1:0] w_occ_next;
  logic             w_full_pulse;

  always_comb begin
    // Events seen while a gate is busy are discarded entirely.
    w_evt_live       = w_evt & w_idle;
    w_exit_ok        = w_evt_live[1] && (r_occ != '0);
    w_exit_bad       = w_evt_live[1] && (r_occ == '0);
    // The exit is resolved first so a simultaneous entry at capacity fits.
    w_occ_after_exit = r_occ - CNT_W'(w_exit_ok);
    w_entry_ok       = w_evt_live[0] && (w_occ_after_exit < c_cap);
    w_entry_rej      = w_evt_live[0] && !w_entry_ok;
    w_occ_next       = w_occ_after_exit + CNT_W'(w_entry_ok);
    w_full_pulse     = w_entry_rej || ((w_occ_next == c_cap) && (r_occ != c_cap));
    w_accept         = {w_exit_ok, w_entry_ok};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_occ      <= '0;
      r_full     <= 1'b0;
      r_exit_err <= 1'b0;
    end else begin
      r_occ      <= w_occ_next;
      r_full     <= w_full_pulse;
      r_exit_err <= w_exit_bad;
    end
  end

`ifdef PARK_STATS_EN
  logic [c_stats_w-1:0] r_total_entries;
  logic [c_stats_w-1:0] r_reject_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_total_entries <= '0;
      r_reject_count  <= '0;
    end else begin
      if (w_entry_ok && (r_total_entries != '1)) r_total_entries <= r_total_entries + 1'b1;
      if (w_entry_rej && (r_reject_count != '1)) r_reject_count  <= r_reject_count + 1'b1;
    end
  end

  assign total_entries = r_total_entries;
  assign reject_count  = r_reject_count;
`endif

  assign entry_gate  = w_gate[0];
  assign exit_gate   = w_gate[1];
  assign occupancy   = r_occ;
  assign full_signal = r_full;
  assign exit_err    = r_exit_err;

endmodule : parking_occupancy_ctrl

`default_nettype wire

// File: tb/tb_parking_occupancy_ctrl.sv
// ============================================================================
//  Module      : tb_parking_occupancy_ctrl
//  Description : Directed self-checking bench for parking_occupancy_ctrl with
//                CAPACITY=2, DEBOUNCE_CYCLES=4, GATE_CYCLES=8. Inputs change
//                and outputs are sampled on the falling clock edge; a raw
//                change made at one falling edge is first sampled by the next
//                rising edge (edge N), so after tick(k) the bench observes the
//                state left by edge N+k-1.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_parking_occupancy_ctrl;

  logic       clk;
  logic       rst;
  logic       entry_sensor;
  logic       exit_sensor;
  logic       entry_gate;
  logic       exit_gate;
  logic [3:0] occupancy;
  logic       full_signal;
  logic       exit_err;
`ifdef PARK_STATS_EN
  logic [15:0] total_entries;
  logic [15:0] reject_count;
`endif

  int n_total = 0;
  int n_pass  = 0;

  parking_occupancy_ctrl #(
    .CAPACITY        (2),
    .CNT_W           (4),
    .DEBOUNCE_CYCLES (4),
    .GATE_CYCLES     (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .entry_sensor (entry_sensor),
    .exit_sensor  (exit_sensor),
    .entry_gate   (entry_gate),
    .exit_gate    (exit_gate),
    .occupancy    (occupancy),
    .full_signal  (full_signal),
    .exit_err     (exit_err)
`ifdef PARK_STATS_EN
    ,
    .total_entries (total_entries),
    .reject_count  (reject_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    rst          = 1'b1;
    entry_sensor = 1'b0;
    exit_sensor  = 1'b0;
    tick(3);
    check("rst_entry_gate", 32'(entry_gate), 32'd0);
    check("rst_exit_gate",  32'(exit_gate),  32'd0);
    check("rst_occupancy",  32'(occupancy),  32'd0);
    check("rst_full",       32'(full_signal), 32'd0);
    check("rst_exit_err",   32'(exit_err),   32'd0);
`ifdef PARK_STATS_EN
    check("rst_total", 32'(total_entries), 32'd0);
    check("rst_reject", 32'(reject_count), 32'd0);
`endif
    rst = 1'b0;
    tick(2);

    // Bounce: only three samples high, never accepted.
    entry_sensor = 1'b1;
    tick(3);
    entry_sensor = 1'b0;
    tick(12);
    check("bounce_occ",  32'(occupancy),  32'd0);
    check("bounce_gate", 32'(entry_gate), 32'd0);

    // First entry: held 10 cycles. Event after edge N+6, decision at N+7.
    entry_sensor = 1'b1;
    tick(7);
    check("e1_occ_before", 32'(occupancy),  32'd0);
    check("e1_gate_before", 32'(entry_gate), 32'd0);
    tick(1);
    check("e1_occ",  32'(occupancy),   32'd1);
    check("e1_gate", 32'(entry_gate),  32'd1);
    check("e1_full", 32'(full_signal), 32'd0);
    tick(2);
    entry_sensor = 1'b0;          // low first sampled at N+10, debounced 0 at N+15
    tick(5);
    check("e1_gate_open_end", 32'(entry_gate), 32'd1);   // N+14, still OPEN
    tick(1);
    check("e1_gate_wait_clr", 32'(entry_gate), 32'd1);   // N+15, WAIT_CLR
    tick(1);
    check("e1_gate_closed",   32'(entry_gate), 32'd0);   // N+16, IDLE
    tick(3);

    // Second entry reaches capacity: one full_signal pulse.
    entry_sensor = 1'b1;
    tick(5);
    entry_sensor = 1'b0;
    tick(3);
    check("e2_occ",  32'(occupancy),   32'd2);
    check("e2_gate", 32'(entry_gate),  32'd1);
    check("e2_full", 32'(full_signal), 32'd1);
    tick(1);
    check("e2_full_single", 32'(full_signal), 32'd0);
    tick(12);
    check("e2_gate_closed", 32'(entry_gate), 32'd0);

    // Third entry at capacity is refused.
    entry_sensor = 1'b1;
    tick(5);
    entry_sensor = 1'b0;
    tick(3);
    check("e3_full", 32'(full_signal), 32'd1);
    check("e3_gate", 32'(entry_gate),  32'd0);
    check("e3_occ",  32'(occupancy),   32'd2);
    tick(1);
    check("e3_full_single", 32'(full_signal), 32'd0);
`ifdef PARK_STATS_EN
    check("e3_total",  32'(total_entries), 32'd2);
    check("e3_reject", 32'(reject_count),  32'd1);
`endif
    tick(8);

    // Simultaneous entry and exit at capacity.
    entry_sensor = 1'b1;
    exit_sensor  = 1'b1;
    tick(6);
    entry_sensor = 1'b0;
    exit_sensor  = 1'b0;
    tick(2);
    check("sim_entry_gate", 32'(entry_gate),  32'd1);
    check("sim_exit_gate",  32'(exit_gate),   32'd1);
    check("sim_occ",        32'(occupancy),   32'd2);
    check("sim_full",       32'(full_signal), 32'd0);
    tick(1);
    check("sim_full_after", 32'(full_signal), 32'd0);
    tick(12);
    check("sim_gates_closed", 32'({entry_gate, exit_gate}), 32'd0);

    // One exit brings the count down to 1.
    exit_sensor = 1'b1;
    tick(5);
    exit_sensor = 1'b0;
    tick(3);
    check("x1_gate", 32'(exit_gate), 32'd1);
    check("x1_occ",  32'(occupancy), 32'd1);
    check("x1_err",  32'(exit_err),  32'd0);
    tick(13);

    // Entry back to capacity, then reset while the gate is OPEN.
    entry_sensor = 1'b1;
    tick(5);
    entry_sensor = 1'b0;
    tick(3);
    check("e4_occ",  32'(occupancy),   32'd2);
    check("e4_full", 32'(full_signal), 32'd1);
    tick(2);
    check("e4_gate_open", 32'(entry_gate), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_gate", 32'(entry_gate),  32'd0);
    check("rst_mid_occ",  32'(occupancy),   32'd0);
    check("rst_mid_full", 32'(full_signal), 32'd0);
`ifdef PARK_STATS_EN
    check("rst_mid_reject", 32'(reject_count),  32'd0);
    check("rst_mid_total",  32'(total_entries), 32'd0);
`endif
    tick(2);
    rst = 1'b0;
    tick(10);

    // Exit while empty.
    exit_sensor = 1'b1;
    tick(5);
    exit_sensor = 1'b0;
    tick(3);
    check("xe_err",  32'(exit_err),  32'd1);
    check("xe_gate", 32'(exit_gate), 32'd0);
    check("xe_occ",  32'(occupancy), 32'd0);
    tick(1);
    check("xe_err_single", 32'(exit_err), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_parking_occupancy_ctrl

`default_nettype wire

// File: doc/parking_occupancy_ctrl.md
# parking_occupancy_ctrl

Tracks car occupancy of the lot from the raw entry and exit sensors, and drives the entry and exit barrier gates. It is the stage directly upstream of the full-indicator blinker. It emits a single-cycle `full_signal` pulse when the lot becomes full and whenever a car is refused entry. It also keeps the occupancy count that the display logic reads.

## Interface
Parameters:
- `CAPACITY`, 8: number of parking slots; range 1..2^CNT_W-1.
- `CNT_W`, 4: width of the occupancy counter.
- `DEBOUNCE_CYCLES`, 4: consecutive stable synchronized samples needed before a sensor level is accepted; must be ≥1.
- `GATE_CYCLES`, 250: minimum number of cycles a gate stays open.

Ports (reset `rst`, asynchronous, active-high; clock `clk`):
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous active-high reset.
- `entry_sensor`  in  1  raw, asynchronous car-present signal at the entry.
- `exit_sensor`  in  1  raw, asynchronous car-present signal at the exit.
- `entry_gate`  out  1  entry barrier open.
- `exit_gate`  out  1  exit barrier open.
- `occupancy`  out  CNT_W  current car count.
- `full_signal`  out  1  one-cycle pulse to the blinker.
- `exit_err`  out  1  one-cycle pulse when an exit arrives while `occupancy` is 0.

## Operation
- Sensor front end, per sensor:
  - 2-flop synchronizer.
  - Debounce counter: the debounced level changes only after DEBOUNCE_CYCLES consecutive samples of the new value.
  - Rising-edge detect on the debounced level produces a one-cycle event.
- Gate FSM, one instance per gate, states IDLE, OPEN, WAIT_CLR:
  - IDLE → OPEN on an accepted event. The gate output is 1 in OPEN and WAIT_CLR, 0 in IDLE.
  - OPEN lasts exactly GATE_CYCLES cycles, then → WAIT_CLR.
  - WAIT_CLR → IDLE in the cycle after the debounced sensor reads 0. If the sensor is already 0, this takes 1 cycle.
  - Events arriving while a gate is not IDLE are dropped: no count change, no pulse.
- Entry event with the gate IDLE:
  - If `occupancy` < CAPACITY: accepted, `occupancy` += 1, entry gate opens.
  - Otherwise: rejected, `full_signal` pulses, gate stays closed.
- Exit event with the gate IDLE:
  - If `occupancy` > 0: accepted, `occupancy` -= 1, exit gate opens.
  - Otherwise: `exit_err` pulses, gate stays closed.
- `full_signal` also pulses in the cycle `occupancy` transitions to CAPACITY. At most one pulse per cycle.
- Simultaneous accepted-eligible entry and exit events in the same cycle:
  - The exit is evaluated first, so at CAPACITY the entry is granted.
  - Net `occupancy` change is 0; both gates open; no `full_signal` pulse.
- Arithmetic: `occupancy` never wraps. The increment is guarded at CAPACITY and the decrement is guarded at 0.

## Timing
- Reset values: `entry_gate`=0, `exit_gate`=0, `occupancy`=0, `full_signal`=0, `exit_err`=0. Synchronizers, debounce counters and FSMs are cleared and FSMs return to IDLE.
- Event latency: a raw edge first sampled at edge N produces its event in cycle N+1+DEBOUNCE_CYCLES+1. For DEBOUNCE_CYCLES=4 this is N+6.
- Decision latency: `occupancy`, gate outputs and pulses are registered and update 1 cycle after the event cycle.
- A reset asserted mid-operation closes both gates immediately (asynchronously) and clears the count. Pulses in flight are lost.
- A bounce shorter than DEBOUNCE_CYCLES samples produces no event.

## Configuration
Macro: `PARK_STATS_EN`.
- Defined: adds outputs `total_entries` (16 bits, counts accepted entries, saturating at 0xFFFF) and `reject_count` (16 bits, counts rejected entries, saturating). Both reset to 0.
- Undefined: these ports and their registers do not exist. All other behaviour is identical.

## Structure
- Package `parking_pkg` holds:
  - the gate-state enum (IDLE/OPEN/WAIT_CLR);
  - default constants for CAPACITY, DEBOUNCE_CYCLES, GATE_CYCLES;
  - the stats counter width (16).
- Sub-module `sensor_debounce` (synchronizer + debounce + rising-edge event), instantiated twice.
- The gate FSM, occupancy counter and pulse logic live in the top module.

## Test plan
All scenarios use CAPACITY=2, DEBOUNCE_CYCLES=4, GATE_CYCLES=8.
- Reset: hold `rst` → all outputs 0. Release, pulse `entry_sensor` for 10 cycles → event at N+6, `occupancy`=1 and `entry_gate`=1 at N+7; the gate stays high for ≥8 cycles and falls 1 cycle after the debounced sensor clears.
- Bounce: toggle `entry_sensor` high for 3 cycles then low → no event, `occupancy` stays 0.
- Fill: two entries → `occupancy`=2 with a single `full_signal` pulse on reaching 2. A third entry → `full_signal` pulse, `entry_gate` stays 0, `occupancy`=2.
- Simultaneous at full: entry and exit events in the same cycle at `occupancy`=2 → both gates open, `occupancy` stays 2, no `full_signal`.
- Empty exit: exit at `occupancy`=0 → `exit_err` pulse, `exit_gate`=0, `occupancy`=0.
- Reset mid-OPEN: assert `rst` while `entry_gate`=1 → gate 0 and `occupancy` 0 immediately. With `PARK_STATS_EN`, `reject_count` returns to 0.
